// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage 64-bit add/sub/compare pipeline with result forwarding and valid/ready handshakes
module alu_exec_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic             in_fwd_a,
    input  logic             in_fwd_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg
);
    logic             s1_v_q, s1_fa_q, s1_fb_q;
    logic [1:0]       s1_op_q;
    logic [63:0]      s1_a_q, s1_b_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s2_v_q, zero_q, neg_q;
    logic [63:0]      res_q, last_res_q;
    logic [TAG_W-1:0] tag_q;
    logic             s2_load, in_fire, out_fire;
    logic [63:0]      opa, opb, res_d;

    // flush blocks the S2 load so last_res keeps its pre-flush value
    assign s2_load  = s1_v_q && (!s2_v_q || out_ready) && !flush;
    assign in_ready = !rst && !flush && (!s1_v_q || s2_load);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_v_q && out_ready;

    always_comb begin
        opa   = s1_fa_q ? last_res_q : s1_a_q;
        opb   = s1_fb_q ? last_res_q : s1_b_q;
        res_d = (s1_op_q == 2'b00) ? opa + opb :
                (s1_op_q == 2'b01) ? opa - opb :
                (s1_op_q == 2'b10) ? {63'd0, $signed(opa) < $signed(opb)} :
                                     {63'd0, opa < opb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_op_q    <= 2'b00;
            s1_a_q     <= 64'd0;
            s1_b_q     <= 64'd0;
            s1_fa_q    <= 1'b0;
            s1_fb_q    <= 1'b0;
            s1_tag_q   <= '0;
            s2_v_q     <= 1'b0;
            res_q      <= 64'd0;
            tag_q      <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            last_res_q <= 64'd0;
        end else begin
            if (in_fire) begin
                s1_op_q  <= in_op;
                s1_a_q   <= in_a;
                s1_b_q   <= in_b;
                s1_fa_q  <= in_fwd_a;
                s1_fb_q  <= in_fwd_b;
                s1_tag_q <= in_tag;
            end
            s1_v_q <= flush ? 1'b0 : in_fire ? 1'b1 : s2_load ? 1'b0 : s1_v_q;
            if (s2_load) begin
                res_q      <= res_d;
                tag_q      <= s1_tag_q;
                zero_q     <= (res_d == 64'd0);
                neg_q      <= res_d[63];
                last_res_q <= res_d;
            end
            s2_v_q <= flush ? 1'b0 : s2_load ? 1'b1 : out_fire ? 1'b0 : s2_v_q;
        end
    end

    assign out_valid  = s2_v_q;
    assign out_result = res_q;
    assign out_tag    = tag_q;
    assign out_zero   = zero_q;
    assign out_neg    = neg_q;
endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The block SHALL have parameter TAG_W, default 5, the width of the destination-register tag carried with each operation.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port flush, input, 1, a synchronous discard of all in-flight operations.
REQ-005 The block SHALL have port in_valid, input, 1, marking an operation presented on the input.
REQ-006 The block SHALL have port in_ready, output, 1, indicating the block accepts an operation this cycle.
REQ-007 The block SHALL have port in_op, input, 2, encoded 00 add, 01 sub (a-b), 10 signed less-than, 11 unsigned less-than.
REQ-008 The block SHALL have ports in_a and in_b, input, 64 each, the operands.
REQ-009 The block SHALL have ports in_fwd_a and in_fwd_b, input, 1 each; each replaces the matching operand with the forwarded result.
REQ-010 The block SHALL have port in_tag, input, TAG_W, the destination tag.
REQ-011 The block SHALL have ports out_valid, output, 1, and out_ready, input, 1, forming the result handshake.
REQ-012 The block SHALL have ports out_result, output, 64; out_tag, output, TAG_W; out_zero, output, 1; and out_neg, output, 1.

Function
REQ-013 A transfer SHALL occur on the input when in_valid&&in_ready, and on the output when out_valid&&out_ready.
REQ-014 Stage S1 SHALL register op, a, b, fwd_a, fwd_b and tag together with a valid bit s1_v.
REQ-015 Stage S2 SHALL register result, tag, zero and neg together with a valid bit s2_v, and out_valid SHALL equal s2_v.
REQ-016 S2 SHALL load from S1 when s1_v && (!s2_v || out_ready).
REQ-017 in_ready SHALL equal !flush && (!s1_v || S2 loads this cycle), so back-to-back throughput is one operation per cycle with no bubble.
REQ-018 Latency SHALL be 2 cycles: an operation accepted in cycle N appears on out_valid in cycle N+2 when the output is not stalled.
REQ-019 The block SHALL hold register last_res, updated with the computed result each time S2 loads.
REQ-020 Forwarding SHALL resolve at S2-load time: with fwd_a set, operand a becomes last_res, so an operation dependent on the immediately preceding operation gets that operation's result.
REQ-021 Add and sub SHALL be modulo 2^64, with carry and borrow discarded.
REQ-022 Compare ops SHALL return 64'd1 if true and 64'd0 otherwise; op 10 treats operands as two's complement, op 11 as unsigned.
REQ-023 out_zero SHALL equal (result==0), and out_neg SHALL equal result[63].
REQ-024 While out_valid=1 and out_ready=0, all out_* outputs SHALL hold stable.
REQ-025 When S1 and S2 are both full and stalled, in_ready SHALL be 0 and no operation SHALL be lost or duplicated.
REQ-026 When flush=1, s1_v and s2_v SHALL clear at the next edge, any simultaneous input SHALL be refused, and last_res SHALL be unchanged.
REQ-027 An output transfer occurring in the same cycle as flush SHALL be counted as completed.

Reset
REQ-028 When rst=1 at a clock edge, s1_v, s2_v, last_res, out_result, out_tag, out_zero and out_neg SHALL become 0, and out_neg SHALL stay 0 while reset is held.
REQ-029 rst SHALL take priority over flush and over all handshakes, and reset applied mid-operation SHALL discard all in-flight work.
REQ-030 in_ready SHALL be 0 during any cycle in which rst=1.

Verification
REQ-031 Directed test: add 5+7, tag 3, out_ready=1 -> out_valid two cycles later, result 12, tag 3, zero 0, neg 0.
REQ-032 Directed test: sub 0-1 -> result 64'hFFFF_FFFF_FFFF_FFFF, neg 1; then op 10 (signed less-than) on that value vs 0 -> result 1, and op 11 (unsigned less-than) on the same pair -> result 0.
REQ-033 Directed test: add 3+4, then a back-to-back add with fwd_a=1 and b=10 -> second result 17, with no bubble between the two outputs.
REQ-034 Directed test: hold out_ready=0 for 5 cycles with 3 operations offered -> exactly 2 accepted, in_ready 0 thereafter, outputs stable; after release, results emerge in order.
REQ-035 Directed test: flush with both stages full -> out_valid 0 next cycle and no stale result appears; the next accepted op forwarding via fwd_a still sees the pre-flush last_res.
REQ-036 Directed test: assert rst mid-stream -> all outputs 0 next cycle and in_ready 0 while rst=1; the first operation after reset is correct.
